alu_req_arbiter: RTL



---
 rtl/alu_req_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin front end that shares one multi-unit ALU
// between NUM_REQ requesters. One operation is in flight at a time; the
// captured result is held on the response channel until accepted.
module alu_req_arbiter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUT_WIDTH  = 17,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   input  logic [NUM_REQ*4-1:0]          req_func,
   output logic [DATA_WIDTH-1:0]         ALU_A,
   output logic [DATA_WIDTH-1:0]         ALU_B,
   output logic [1:0]                    ALU_FUNC,
   output logic                          Arith_Enable,
   output logic                          Logic_Enable,
   output logic                          CMP_Enable,
   output logic                          Shift_Enable,
   input  logic [OUT_WIDTH-1:0]          ALU_OUT,
   input  logic                          OUT_VALID,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [OUT_WIDTH-1:0]          rsp_data,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic                          rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state, state_nxt;
   logic [ID_WIDTH-1:0]   last_grant;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  grant_found;
   int unsigned           rr_idx;
   logic [DATA_WIDTH-1:0] sel_a, sel_b;
   logic [3:0]            sel_func;
   logic [DATA_WIDTH-1:0] lat_a, lat_b;
   logic [3:0]            lat_func;
   logic [ID_WIDTH-1:0]   lat_id;
   logic [OUT_WIDTH-1:0]  data_q;
   logic                  err_q;

   // Round-robin search: first valid requester after the last one served.
   always_comb begin
      rr_idx      = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         rr_idx = (32'(last_grant) + k) % NUM_REQ;
         if (!grant_found && ((req_valid >> rr_idx) & NUM_REQ'(1)) != '0) begin
            grant_found = 1'b1;
            grant_idx   = ID_WIDTH'(rr_idx);
         end
      end
   end

   // Select the operands and function of the requester being granted.
   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_func = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_WIDTH'(i)) begin
            sel_a    = DATA_WIDTH'(req_a >> (i * DATA_WIDTH));
            sel_b    = DATA_WIDTH'(req_b >> (i * DATA_WIDTH));
            sel_func = 4'(req_func >> (i * 4));
         end
      end
   end

   // Accept pulse only in IDLE, and never while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (RST && state == S_IDLE && grant_found)
         req_ready = NUM_REQ'(1) << grant_idx;
   end

   // Next-state logic and per-state outputs.
   always_comb begin
      state_nxt    = state;
      Arith_Enable = 1'b0;
      Logic_Enable = 1'b0;
      CMP_Enable   = 1'b0;
      Shift_Enable = 1'b0;
      rsp_valid    = 1'b0;
      case (state)
         S_IDLE: begin
            if (grant_found) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            case (lat_func[3:2])
               2'b00:   Arith_Enable = 1'b1;
               2'b01:   Logic_Enable = 1'b1;
               2'b10:   CMP_Enable   = 1'b1;
               default: Shift_Enable = 1'b1;
            endcase
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, request latch, result capture and round-robin pointer.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= S_IDLE;
         last_grant <= ID_WIDTH'(NUM_REQ - 1);
         lat_a      <= '0;
         lat_b      <= '0;
         lat_func   <= '0;
         lat_id     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && grant_found) begin
            lat_a    <= sel_a;
            lat_b    <= sel_b;
            lat_func <= sel_func;
            lat_id   <= grant_idx;
         end
         if (state == S_WAIT) begin
            data_q <= OUT_VALID ? ALU_OUT : '0;
            err_q  <= ~OUT_VALID;
         end
         if (state == S_RESP && rsp_ready)
            last_grant <= lat_id;
      end
   end

   assign ALU_A    = lat_a;
   assign ALU_B    = lat_b;
   assign ALU_FUNC = lat_func[1:0];
   assign rsp_data = data_q;
   assign rsp_id   = lat_id;
   assign rsp_err  = err_q;

endmodule
